// File: rtl/fp32_mul_issue.sv
// Flow-controlled wrapper around a combinational IEEE-754 single-precision
// multiplier: operand FIFO in front, registered result slot with
// classification flags behind.
module fp32_mul_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  input  logic [31:0]   mul_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [3:0]    out_flags,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          alive;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic          not_empty;
  logic [3:0]    head_flags;

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return v[30:0] == 31'd0;
  endfunction

  // {invalid, nan, inf, zero}: invalid looks at the operands, the rest at the product
  function automatic logic [3:0] classify(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r);
    logic invalid;
    invalid = (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)) ||
              is_nan(a) || is_nan(b);
    return {invalid, is_nan(r), is_inf(r), is_zero(r)};
  endfunction

  // alive gates in_ready so nothing is accepted while reset is asserted
  assign in_ready   = alive && (count_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign not_empty  = (count_q != '0);
  assign slot_free  = !out_valid || out_ready;
  assign pop        = not_empty && slot_free;
  assign count      = count_q;

  // An empty FIFO presents zeros so the multiplier never sees stale or unwritten entries
  assign mul_a      = not_empty ? mem_a[rd_ptr] : 32'd0;
  assign mul_b      = not_empty ? mem_b[rd_ptr] : 32'd0;
  assign head_flags = classify(mul_a, mul_b, mul_result);

  // Operand storage: data only, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO control: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      alive <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Output slot: capture the product on pop, drop valid when consumed without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_flags  <= 4'd0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= mul_result;
      out_flags  <= head_flags;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
